// File: rtl/sbrk_rom_loader.sv
// sbrk_rom_loader: routes the HPS ROM download into Super Breakout ROM/PROM regions and holds the core in reset around loads
module sbrk_rom_loader #(
  parameter logic [16:0] PROG_END = 17'h01800,
  parameter logic [16:0] CHAR_END = 17'h01A00,
  parameter logic [16:0] PROM_END = 17'h01C00,
  parameter logic [15:0] HOLD_CYC = 16'd4096
) (
  input  logic        clk_sys,
  input  logic        Reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [16:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        user_reset,
  output logic        prog_we,
  output logic        char_we,
  output logic        prom_we,
  output logic [12:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        core_reset_n,
  output logic        loaded,
  output logic        dl_error,
  output logic        mute
);
  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [1:0] RUN  = 2'd3;
  logic [1:0]  state, state_n;
  logic        dl_q, rise, fall, acc, in_prog, in_char, in_prom, err_n, hold_done;
  logic [16:0] cnt, cnt_n;
  logic [15:0] hold_cnt;
  logic [12:0] off;
  // edge detect, region decode, byte count and next-state selection
  always_comb begin
    rise      = ioctl_download & ~dl_q;
    fall      = ~ioctl_download & dl_q & (state == LOAD);
    acc       = ioctl_wr & ((state == LOAD) | rise);
    in_prog   = ioctl_addr < PROG_END;
    in_char   = ~in_prog & (ioctl_addr < CHAR_END);
    in_prom   = ~in_prog & ~in_char & (ioctl_addr < PROM_END);
    off       = ioctl_addr[12:0] - (in_prog ? 13'd0 : in_char ? PROG_END[12:0] : CHAR_END[12:0]);
    cnt_n     = (rise ? 17'd0 : cnt) + {16'd0, acc};
    err_n     = (~rise & dl_error) | (acc & ~in_prog & ~in_char & ~in_prom) | (fall & (cnt_n < PROM_END));
    hold_done = (state == HOLD) & (hold_cnt == HOLD_CYC - 16'd1);
    state_n   = rise ? LOAD : fall ? HOLD : hold_done ? (loaded ? RUN : BOOT) : state;
  end
  // registered state, write strobes and reset/mute arbitration
  always_ff @(posedge clk_sys or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= BOOT;
      dl_q         <= 1'b0;
      cnt          <= 17'd0;
      hold_cnt     <= 16'd0;
      prog_we      <= 1'b0;
      char_we      <= 1'b0;
      prom_we      <= 1'b0;
      dn_addr      <= 13'd0;
      dn_data      <= 8'd0;
      core_reset_n <= 1'b0;
      loaded       <= 1'b0;
      dl_error     <= 1'b0;
      mute         <= 1'b1;
    end else begin
      state        <= state_n;
      dl_q         <= ioctl_download;
      cnt          <= cnt_n;
      hold_cnt     <= (state == HOLD) ? hold_cnt + 16'd1 : 16'd0;
      prog_we      <= acc & in_prog;
      char_we      <= acc & in_char;
      prom_we      <= acc & in_prom;
      dl_error     <= err_n;
      loaded       <= loaded | (fall & ~err_n);
      core_reset_n <= (state_n == RUN) & ~user_reset;
      mute         <= state_n != RUN;
      if (acc & (in_prog | in_char | in_prom)) begin
        dn_addr <= off;
        dn_data <= ioctl_dout;
      end
    end
  end
endmodule

// File: tb/tb_sbrk_rom_loader.sv
// tb_sbrk_rom_loader: directed sequence with random data/gaps checked against a region/count model
module tb_sbrk_rom_loader;
  logic        clk_sys = 1'b0;
  logic        Reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [16:0] ioctl_addr = 17'd0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic        user_reset = 1'b0;
  logic        prog_we, char_we, prom_we, core_reset_n, loaded, dl_error, mute;
  logic [12:0] dn_addr;
  logic [7:0]  dn_data;
  int compared = 0;
  int mismatched = 0;
  int n_prog = 0, n_char = 0, n_prom = 0;
  int exp_cnt;
  bit bad_seen;
  bit exp_loaded = 1'b0;
  logic [7:0] last_d;

  sbrk_rom_loader dut (
    .clk_sys(clk_sys), .Reset_n(Reset_n), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .user_reset(user_reset),
    .prog_we(prog_we), .char_we(char_we), .prom_we(prom_we), .dn_addr(dn_addr), .dn_data(dn_data),
    .core_reset_n(core_reset_n), .loaded(loaded), .dl_error(dl_error), .mute(mute)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    if (prog_we) n_prog++;
    if (char_we) n_char++;
    if (prom_we) n_prom++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_byte(input logic [16:0] a, input int gap);
    logic [7:0]  d;
    logic [16:0] base;
    logic [16:0] off;
    logic [2:0]  kind;
    d = 8'($urandom);
    ioctl_wr = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    exp_cnt++;
    if (a < 17'h1800) begin kind = 3'b100; base = 17'h0; end
    else if (a < 17'h1A00) begin kind = 3'b010; base = 17'h1800; end
    else if (a < 17'h1C00) begin kind = 3'b001; base = 17'h1A00; end
    else begin kind = 3'b000; base = 17'h0; bad_seen = 1'b1; end
    off = a - base;
    if (kind == 3'b000) begin
      chk("bad_we", {29'd0, prog_we, char_we, prom_we}, 32'd0);
      chk("bad_err", {31'd0, dl_error}, 32'd1);
    end else begin
      last_d = d;
      chk("wr", {8'd0, prog_we, char_we, prom_we, dn_addr, dn_data}, {8'd0, kind, off[12:0], d});
    end
    repeat (gap) @(negedge clk_sys);
  endtask

  task automatic download(input int n, input int gap, input bit bad, input bit fall_last, input bit rand_gap);
    exp_cnt = 0;
    bad_seen = 1'b0;
    ioctl_download = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (bad && i == 100) wr_byte(17'h1C10, gap);
      if (fall_last && i == n - 1) ioctl_download = 1'b0;
      wr_byte(17'(i), rand_gap ? int'($urandom_range(0, 1)) : gap);
    end
    ioctl_download = 1'b0;
  endtask

  task automatic after_dl(input bit fell);
    int n;
    bit ok;
    bit e;
    e = bad_seen || exp_cnt < 32'h1C00;
    exp_loaded = exp_loaded | ~e;
    n = fell ? 1 : 0;
    ok = 1'b1;
    if (exp_loaded) begin
      while (n < 6000) begin
        @(negedge clk_sys);
        if (core_reset_n === 1'b1) break;
        ok &= (mute === 1'b1);
        n++;
      end
      chk("hold_len", n, 4096);
      chk("hold_mute", {31'd0, ok}, 32'd1);
      chk("run_mute", {31'd0, mute}, 32'd0);
    end else begin
      repeat (4400) begin
        @(negedge clk_sys);
        ok &= (core_reset_n === 1'b0) && (mute === 1'b1);
      end
      chk("boot_stay", {31'd0, ok}, 32'd1);
    end
    chk("dl_error", {31'd0, dl_error}, {31'd0, e});
    chk("loaded", {31'd0, loaded}, {31'd0, exp_loaded});
  endtask

  initial begin
    bit ok;
    int p0, c0, r0;
    logic [4:0] s;
    repeat (3) @(negedge clk_sys);
    chk("reset_vals", {4'd0, prog_we, char_we, prom_we, dn_addr, dn_data, core_reset_n, loaded, dl_error, mute},
        {4'd0, 3'b000, 13'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    Reset_n = 1'b1;
    ok = 1'b1;
    repeat (10000) begin
      @(negedge clk_sys);
      ok &= (core_reset_n === 1'b0) && (loaded === 1'b0) && (mute === 1'b1);
    end
    chk("idle", {31'd0, ok}, 32'd1);
    download($urandom_range(32'h100, 32'h400), 0, 1'b0, 1'b0, 1'b1);
    after_dl(1'b0);
    p0 = n_prog; c0 = n_char; r0 = n_prom;
    download(32'h1C00, 3, 1'b0, 1'b0, 1'b0);
    after_dl(1'b0);
    chk("prog_pulses", n_prog - p0, 32'h1800);
    chk("char_pulses", n_char - c0, 32'h200);
    chk("prom_pulses", n_prom - r0, 32'h200);
    chk("dn_hold", {11'd0, dn_addr, dn_data}, {11'd0, 13'h1FF, last_d});
    user_reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_sys);
      s[4-k] = core_reset_n;
      if (k == 2) user_reset = 1'b0;
    end
    chk("user_reset", {27'd0, s}, {27'd0, 5'b00011});
    chk("ur_loaded", {31'd0, loaded}, 32'd1);
    chk("ur_mute", {31'd0, mute}, 32'd0);
    download(32'h1C00, 0, 1'b1, 1'b0, 1'b0);
    chk("reload_mute", {30'd0, mute, core_reset_n}, {30'd0, 1'b1, 1'b0});
    after_dl(1'b0);
    ioctl_download = 1'b1;
    exp_cnt = 0;
    for (int i = 0; i < 300; i++) wr_byte(17'(i), 0);
    #2 Reset_n = 1'b0;
    #1 chk("async_rst", {4'd0, prog_we, char_we, prom_we, dn_addr, dn_data, core_reset_n, loaded, dl_error, mute},
           {4'd0, 3'b000, 13'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    exp_loaded = 1'b0;
    repeat (2) @(negedge clk_sys);
    Reset_n = 1'b1;
    download(32'h1C00, 0, 1'b0, 1'b1, 1'b0);
    after_dl(1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
